// File: rtl/partsel_reg.sv
// Runtime-indexed bit/part-select register with a one-entry response buffer.
// Every accepted command updates the state vector and loads a response in the same edge.
module partsel_reg #(
  parameter  int               WIDTH     = 10,
  parameter  int               FIELD_W   = 2,
  parameter  logic [WIDTH-1:0] RESET_VAL = '1,
  localparam int               IDX_W     = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [IDX_W-1:0]   cmd_idx,
  input  logic [FIELD_W-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [FIELD_W-1:0] rsp_data,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   reg_q
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } rsp_state_t;

  localparam logic [1:0] OP_BIT_WR = 2'b00;
  localparam logic [1:0] OP_FLD_WR = 2'b01;
  localparam logic [1:0] OP_FLD_RD = 2'b10;
  localparam logic [1:0] OP_FILL   = 2'b11;

  localparam logic [IDX_W:0]   C_WIDTH = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W:0]   C_FIELD = (IDX_W+1)'(FIELD_W);
  localparam logic [WIDTH-1:0] C_FMASK = WIDTH'({FIELD_W{1'b1}});
  localparam logic [WIDTH-1:0] C_BMASK = {{(WIDTH-1){1'b0}}, 1'b1};

  rsp_state_t         r_state;
  rsp_state_t         w_state_nxt;
  logic [WIDTH-1:0]   r_q;
  logic [FIELD_W-1:0] r_rsp_data;
  logic               r_rsp_err;

  logic               w_accept;
  logic [IDX_W:0]     w_idx_ext;
  logic               w_bit_err;
  logic               w_fld_err;
  logic [WIDTH-1:0]   w_bmask;
  logic [WIDTH-1:0]   w_fmask;
  logic [WIDTH-1:0]   w_fdata;
  logic               w_old_bit;
  logic [FIELD_W-1:0] w_old_field;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [FIELD_W-1:0] w_rsp_data_nxt;
  logic               w_rsp_err_nxt;

  assign w_accept = cmd_valid && cmd_ready;

  // Range check is done one bit wider than the index so idx + FIELD_W cannot wrap.
  assign w_idx_ext = {1'b0, cmd_idx};
  assign w_bit_err = (w_idx_ext >= C_WIDTH);
  assign w_fld_err = ((w_idx_ext + C_FIELD) > C_WIDTH);

  // Shift-based select keeps out-of-range indices from producing X in simulation.
  assign w_bmask     = C_BMASK << cmd_idx;
  assign w_fmask     = C_FMASK << cmd_idx;
  assign w_fdata     = WIDTH'(cmd_data) << cmd_idx;
  assign w_old_bit   = |(r_q & w_bmask);
  assign w_old_field = FIELD_W'(r_q >> cmd_idx);

  always_comb begin
    w_q_nxt        = r_q;
    w_rsp_data_nxt = '0;
    w_rsp_err_nxt  = 1'b0;
    case (cmd_op)
      OP_BIT_WR: begin
        if (w_bit_err) begin
          w_rsp_err_nxt = 1'b1;
        end else begin
          w_q_nxt        = (r_q & ~w_bmask) | (cmd_data[0] ? w_bmask : '0);
          w_rsp_data_nxt = FIELD_W'(w_old_bit);
        end
      end
      OP_FLD_WR: begin
        if (w_fld_err) begin
          w_rsp_err_nxt = 1'b1;
        end else begin
          w_q_nxt        = (r_q & ~w_fmask) | (w_fdata & w_fmask);
          w_rsp_data_nxt = w_old_field;
        end
      end
      OP_FLD_RD: begin
        if (w_fld_err) begin
          w_rsp_err_nxt = 1'b1;
        end else begin
          w_rsp_data_nxt = w_old_field;
        end
      end
      OP_FILL: begin
        w_q_nxt = {WIDTH{cmd_data[0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = (r_state == S_EMPTY) || rsp_ready;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (rsp_ready && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= RESET_VAL;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_q        <= w_q_nxt;
      r_rsp_data <= w_rsp_data_nxt;
      r_rsp_err  <= w_rsp_err_nxt;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign reg_q     = r_q;

endmodule

// File: tb/tb_partsel_reg.sv
// Checks partsel_reg in three configurations (10/2, 16/4, 2/2) sharing one stimulus bus.
module tb_partsel_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] sel;
  logic       cmd_valid, rsp_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_idx, cmd_data;

  logic vA, vB, vC, rrA, rrB, rrC;
  logic rdyA, rdyB, rdyC, rvA, rvB, rvC, erA, erB, erC;
  logic [1:0] rdA, rdC;
  logic [3:0] rdB;
  logic [9:0] qA;
  logic [15:0] qB;
  logic [1:0] qC;

  assign vA  = cmd_valid && (sel == 2'd0);
  assign vB  = cmd_valid && (sel == 2'd1);
  assign vC  = cmd_valid && (sel == 2'd2);
  assign rrA = rsp_ready && (sel == 2'd0);
  assign rrB = rsp_ready && (sel == 2'd1);
  assign rrC = rsp_ready && (sel == 2'd2);

  partsel_reg u_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vA), .cmd_ready(rdyA), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_data(cmd_data[1:0]), .rsp_valid(rvA), .rsp_ready(rrA),
    .rsp_data(rdA), .rsp_err(erA), .reg_q(qA));

  partsel_reg #(.WIDTH(16), .FIELD_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vB), .cmd_ready(rdyB), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_data(cmd_data), .rsp_valid(rvB), .rsp_ready(rrB),
    .rsp_data(rdB), .rsp_err(erB), .reg_q(qB));

  partsel_reg #(.WIDTH(2), .FIELD_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vC), .cmd_ready(rdyC), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx[0:0]), .cmd_data(cmd_data[1:0]), .rsp_valid(rvC), .rsp_ready(rrC),
    .rsp_data(rdC), .rsp_err(erC), .reg_q(qC));

  logic        o_ready, o_rvalid, o_rerr;
  logic [3:0]  o_rdata;
  logic [15:0] o_q;

  always_comb begin
    o_ready = 1'b0; o_rvalid = 1'b0; o_rerr = 1'b0; o_rdata = '0; o_q = '0;
    case (sel)
      2'd0: begin o_ready = rdyA; o_rvalid = rvA; o_rerr = erA; o_rdata = {2'b0, rdA}; o_q = {6'b0, qA}; end
      2'd1: begin o_ready = rdyB; o_rvalid = rvB; o_rerr = erB; o_rdata = rdB; o_q = qB; end
      2'd2: begin o_ready = rdyC; o_rvalid = rvC; o_rerr = erC; o_rdata = {2'b0, rdC}; o_q = {14'b0, qC}; end
      default: ;
    endcase
  end

  int ntests = 0;
  int nfail  = 0;

  int W[3]  = '{10, 16, 2};
  int F[3]  = '{2, 4, 2};
  int IW[3] = '{4, 4, 1};

  // Reference model: state vector plus response buffer per configuration.
  logic [15:0] mq[3];
  logic        mv[3];
  logic [3:0]  mrd[3];
  logic        merr[3];

  function automatic logic [15:0] rstval(input int s);
    return 16'((32'h1 << W[s]) - 1);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) begin
      mq[s] = rstval(s); mv[s] = 1'b0; mrd[s] = '0; merr[s] = 1'b0;
    end
  endfunction

  function automatic void model_cmd(input int s, input int op, input int idx,
                                    input logic [3:0] data,
                                    output logic [3:0] rd, output logic er);
    rd = '0; er = 1'b0;
    case (op)
      0: if (idx >= W[s]) er = 1'b1;
         else begin rd[0] = mq[s][idx]; mq[s][idx] = data[0]; end
      1, 2: if (idx + F[s] > W[s]) er = 1'b1;
         else for (int i = 0; i < F[s]; i++) begin
           rd[i] = mq[s][idx + i];
           if (op == 1) mq[s][idx + i] = data[i];
         end
      default: for (int i = 0; i < W[s]; i++) mq[s][i] = data[0];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    int          s;
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [3:0]  data;
    logic [3:0]  rd;
    logic        er;
    logic [15:0] q;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input int s, input logic [1:0] op, input logic [3:0] idx,
                              input logic [3:0] data, input logic [3:0] rd,
                              input logic er, input logic [15:0] q);
    vec_t v;
    v.s = s; v.op = op; v.idx = idx; v.data = data; v.rd = rd; v.er = er; v.q = q;
    tv.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] erd;
    logic       eer;
    int         s;
    logic       acc;

    rst_n = 1'b0; sel = '0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_idx = '0; cmd_data = '0;

    // Width 10 / field 2
    add(0, 2'b10, 4'd0,  4'h0, 4'h3, 1'b0, 16'h03ff);
    add(0, 2'b01, 4'd4,  4'h1, 4'h3, 1'b0, 16'h03df);
    add(0, 2'b10, 4'd4,  4'h0, 4'h1, 1'b0, 16'h03df);
    add(0, 2'b01, 4'd9,  4'h0, 4'h0, 1'b1, 16'h03df);
    add(0, 2'b00, 4'd10, 4'h0, 4'h0, 1'b1, 16'h03df);
    add(0, 2'b10, 4'd15, 4'h0, 4'h0, 1'b1, 16'h03df);
    add(0, 2'b01, 4'd8,  4'h0, 4'h3, 1'b0, 16'h00df);
    add(0, 2'b11, 4'd0,  4'h0, 4'h0, 1'b0, 16'h0000);
    add(0, 2'b00, 4'd9,  4'h1, 4'h0, 1'b0, 16'h0200);
    add(0, 2'b00, 4'd9,  4'h0, 4'h1, 1'b0, 16'h0000);
    add(0, 2'b11, 4'd7,  4'h1, 4'h0, 1'b0, 16'h03ff);
    // Width 16 / field 4
    add(1, 2'b10, 4'd0,  4'h0, 4'hf, 1'b0, 16'hffff);
    add(1, 2'b01, 4'd12, 4'h5, 4'hf, 1'b0, 16'h5fff);
    add(1, 2'b10, 4'd12, 4'h0, 4'h5, 1'b0, 16'h5fff);
    add(1, 2'b10, 4'd13, 4'h0, 4'h0, 1'b1, 16'h5fff);
    add(1, 2'b00, 4'd15, 4'h0, 4'h0, 1'b0, 16'h5fff);
    add(1, 2'b01, 4'd3,  4'h0, 4'hf, 1'b0, 16'h5f87);
    add(1, 2'b11, 4'd0,  4'he, 4'h0, 1'b0, 16'h0000);
    add(1, 2'b00, 4'd4,  4'h3, 4'h0, 1'b0, 16'h0010);
    // Width 2 / field 2
    add(2, 2'b10, 4'd0,  4'h0, 4'h3, 1'b0, 16'h0003);
    add(2, 2'b10, 4'd1,  4'h0, 4'h0, 1'b1, 16'h0003);
    add(2, 2'b01, 4'd0,  4'h2, 4'h3, 1'b0, 16'h0002);
    add(2, 2'b00, 4'd1,  4'h0, 4'h1, 1'b0, 16'h0000);
    add(2, 2'b00, 4'd0,  4'h1, 4'h0, 1'b0, 16'h0001);
    add(2, 2'b11, 4'd0,  4'h2, 4'h0, 1'b0, 16'h0000);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k); #1;
      chk($sformatf("reset rsp_valid c%0d", k), o_rvalid, 0);
      chk($sformatf("reset rsp_data c%0d", k), o_rdata, 0);
      chk($sformatf("reset rsp_err c%0d", k), o_rerr, 0);
      chk($sformatf("reset reg_q c%0d", k), o_q, rstval(k));
    end

    foreach (tv[i]) begin
      @(negedge clk);
      sel = 2'(tv[i].s); cmd_op = tv[i].op; cmd_idx = tv[i].idx; cmd_data = tv[i].data;
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      #1 chk($sformatf("tbl%0d cmd_ready", i), o_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk($sformatf("tbl%0d rsp_valid", i), o_rvalid, 1);
      chk($sformatf("tbl%0d rsp_data", i), o_rdata, tv[i].rd);
      chk($sformatf("tbl%0d rsp_err", i), o_rerr, tv[i].er);
      chk($sformatf("tbl%0d reg_q", i), o_q, tv[i].q);
    end

    // Backpressure then pass-through accept, each configuration
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sel = 2'(k); rsp_ready = 1'b0;
      cmd_op = 2'b01; cmd_idx = 4'd0; cmd_data = 4'ha; cmd_valid = 1'b1;
      #1 chk($sformatf("bp%0d first ready", k), o_ready, 1);
      @(posedge clk); #1;
      model_cmd(k, 1, 0, 4'ha, erd, eer);
      chk($sformatf("bp%0d rsp_valid", k), o_rvalid, 1);
      chk($sformatf("bp%0d rsp_data", k), o_rdata, erd);
      cmd_op = 2'b10;
      for (int h = 0; h < 3; h++) begin
        @(posedge clk); #1;
        chk($sformatf("bp%0d hold ready", k), o_ready, 0);
        chk($sformatf("bp%0d hold valid", k), o_rvalid, 1);
        chk($sformatf("bp%0d hold data", k), o_rdata, erd);
        chk($sformatf("bp%0d hold reg_q", k), o_q, mq[k]);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1 chk($sformatf("bp%0d release ready", k), o_ready, 1);
      @(posedge clk); #1;
      model_cmd(k, 2, 0, 4'h0, erd, eer);
      chk($sformatf("bp%0d pass valid", k), o_rvalid, 1);
      chk($sformatf("bp%0d pass raw data", k), o_rdata, erd);
      chk($sformatf("bp%0d pass err", k), o_rerr, eer);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp%0d drained", k), o_rvalid, 0);
    end

    // Asynchronous reset with a response pending
    @(negedge clk);
    sel = 2'd0; rsp_ready = 1'b0; cmd_op = 2'b11; cmd_idx = '0; cmd_data = 4'h0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("midrst pending valid", o_rvalid, 1);
    chk("midrst filled reg_q", o_q, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst async valid", o_rvalid, 0);
    chk("midrst async reg_q", o_q, 16'h03ff);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; model_reset();
    cmd_op = 2'b10; cmd_idx = 4'd0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("midrst first accept valid", o_rvalid, 1);
    chk("midrst first accept data", o_rdata, 4'h3);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 900; n++) begin
      @(negedge clk);
      s = $urandom_range(0, 2);
      sel = 2'(s);
      cmd_op = 2'($urandom);
      cmd_idx = 4'($urandom_range(0, (1 << IW[s]) - 1));
      cmd_data = 4'($urandom);
      cmd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      acc = cmd_valid && (!mv[s] || rsp_ready);
      #1 chk("rnd cmd_ready", o_ready, !mv[s] || rsp_ready);
      @(posedge clk); #1;
      if (acc) begin
        model_cmd(s, int'(cmd_op), int'(cmd_idx), cmd_data, mrd[s], merr[s]);
        mv[s] = 1'b1;
      end else if (rsp_ready) begin
        mv[s] = 1'b0;
      end
      chk("rnd rsp_valid", o_rvalid, mv[s]);
      if (mv[s]) begin
        chk("rnd rsp_data", o_rdata, mrd[s]);
        chk("rnd rsp_err", o_rerr, merr[s]);
      end
      chk("rnd reg_q", o_q, mq[s]);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
